// File: rtl/exhaustive_bist_ctrl.sv
// Exhaustive-sweep BIST controller: walks all 2^IN_W patterns, folds responses into a MISR.
// Optional BIST_EXPECT_EN adds per-vector compare against exp_in (err_cnt, first_fail).
module exhaustive_bist_ctrl #(
  parameter int               IN_W   = 3,
  parameter int               OUT_W  = 2,
  parameter int               SIG_W  = 16,
  parameter int               SETTLE = 1,
  parameter logic [SIG_W-1:0] POLY   = 16'h8005,
  parameter logic [SIG_W-1:0] SEED   = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [SIG_W-1:0] golden_sig,
  output logic [IN_W-1:0]  pat_out,
  input  logic [OUT_W-1:0] resp_in,
`ifdef BIST_EXPECT_EN
  input  logic [OUT_W-1:0] exp_in,
  output logic [IN_W:0]    err_cnt,
  output logic [IN_W-1:0]  first_fail,
`endif
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature,
  output logic [IN_W-1:0]  vec_idx
);

  if (OUT_W > SIG_W || SETTLE < 1 || SIG_W < 2 ||
      IN_W < 1 || IN_W > 16) begin : g_param_err
    $error("exhaustive_bist_ctrl: illegal parameters");
  end

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(SETTLE - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_APPLY   = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_CHECK   = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [IN_W-1:0]  pat_q, pat_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic             pass_q, pass_d;
  logic [SIG_W-1:0] resp_ext;
  logic [SIG_W-1:0] misr_nxt;
  logic             err_ok;

`ifdef BIST_EXPECT_EN
  logic [IN_W:0]   err_q, err_d;
  logic [IN_W-1:0] ff_q, ff_d;
  assign err_ok = (err_q == '0);
`else
  assign err_ok = 1'b1;
`endif

  always_comb begin
    resp_ext = '0;
    resp_ext[OUT_W-1:0] = resp_in;
  end

  assign misr_nxt = {sig_q[SIG_W-2:0], 1'b0}
                  ^ (sig_q[SIG_W-1] ? POLY : '0)
                  ^ resp_ext;

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    sig_d   = sig_q;
    pass_d  = pass_q;
`ifdef BIST_EXPECT_EN
    err_d   = err_q;
    ff_d    = ff_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_APPLY;
          pat_d   = '0;
          cnt_d   = RELOAD;
          sig_d   = SEED;
          pass_d  = 1'b0;
`ifdef BIST_EXPECT_EN
          err_d   = '0;
          ff_d    = '0;
`endif
        end
      end
      S_APPLY: begin
        if (cnt_q == '0) state_d = S_CAPTURE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_CAPTURE: begin
        sig_d = misr_nxt;
`ifdef BIST_EXPECT_EN
        if (resp_in != exp_in) begin
          if (err_q != '1) err_d = err_q + 1'b1;
          if (err_q == '0) ff_d  = pat_q;
        end
`endif
        if (&pat_q) begin
          state_d = S_CHECK;
        end else begin
          state_d = S_APPLY;
          pat_d   = pat_q + 1'b1;
          cnt_d   = RELOAD;
        end
      end
      S_CHECK: begin
        pass_d  = (sig_q == golden_sig) && err_ok;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      cnt_q   <= '0;
      sig_q   <= SEED;
      pass_q  <= 1'b0;
`ifdef BIST_EXPECT_EN
      err_q   <= '0;
      ff_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      sig_q   <= sig_d;
      pass_q  <= pass_d;
`ifdef BIST_EXPECT_EN
      err_q   <= err_d;
      ff_q    <= ff_d;
`endif
    end
  end

  assign busy      = (state_q == S_APPLY) ||
                     (state_q == S_CAPTURE) ||
                     (state_q == S_CHECK);
  assign done      = (state_q == S_DONE);
  assign pass      = pass_q;
  assign signature = sig_q;
  assign pat_out   = pat_q;
  assign vec_idx   = pat_q;
`ifdef BIST_EXPECT_EN
  assign err_cnt    = err_q;
  assign first_fail = ff_q;
`endif

endmodule

// File: tb/tb_exhaustive_bist_ctrl.sv
// Randomized bench for exhaustive_bist_ctrl against a behavioural MISR model.
// Two instances: default config and IN_W=2/SETTLE=3.
module tb_exhaustive_bist_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_a, start_b;
  logic [15:0] golden;
  logic        stuck;
  int          sel;
  int          n_chk = 0;
  int          n_err = 0;

  logic [1:0]  resp_tab [16];
  logic [1:0]  exp_tab  [16];

  logic [2:0]  pat_a, vec_a;
  logic [1:0]  pat_b, vec_b;
  logic [1:0]  resp_a, resp_b, exp_a, exp_b;
  logic        busy_a, done_a, pass_a;
  logic        busy_b, done_b, pass_b;
  logic [15:0] sig_a, sig_b;
  logic [3:0]  errc_a;
  logic [2:0]  errc_b;
  logic [2:0]  ff_a;
  logic [1:0]  ff_b;

  logic [15:0] o_pat, o_sig;
  logic        o_busy, o_done, o_pass;

  always #5 clk = ~clk;

  assign resp_a = resp_tab[pat_a] | {1'b0, stuck};
  assign resp_b = resp_tab[pat_b] | {1'b0, stuck};
  assign exp_a  = exp_tab[pat_a];
  assign exp_b  = resp_b;

  assign o_pat  = (sel != 0) ? 16'(pat_b) : 16'(pat_a);
  assign o_sig  = (sel != 0) ? sig_b  : sig_a;
  assign o_busy = (sel != 0) ? busy_b : busy_a;
  assign o_done = (sel != 0) ? done_b : done_a;
  assign o_pass = (sel != 0) ? pass_b : pass_a;

  exhaustive_bist_ctrl u_dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start_a),
    .golden_sig (golden),
    .pat_out    (pat_a),
    .resp_in    (resp_a),
`ifdef BIST_EXPECT_EN
    .exp_in     (exp_a),
    .err_cnt    (errc_a),
    .first_fail (ff_a),
`endif
    .busy       (busy_a),
    .done       (done_a),
    .pass       (pass_a),
    .signature  (sig_a),
    .vec_idx    (vec_a)
  );

  exhaustive_bist_ctrl #(.IN_W(2), .SETTLE(3)) u_dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start_b),
    .golden_sig (golden),
    .pat_out    (pat_b),
    .resp_in    (resp_b),
`ifdef BIST_EXPECT_EN
    .exp_in     (exp_b),
    .err_cnt    (errc_b),
    .first_fail (ff_b),
`endif
    .busy       (busy_b),
    .done       (done_b),
    .pass       (pass_b),
    .signature  (sig_b),
    .vec_idx    (vec_b)
  );

`ifndef BIST_EXPECT_EN
  assign errc_a = '0;
  assign errc_b = '0;
  assign ff_a   = '0;
  assign ff_b   = '0;
`endif

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] misr(input logic [15:0] s,
                                       input logic [1:0] r);
    logic [15:0] nx;
    nx = (s << 1) ^ {14'd0, r};
    if (s >= 16'h8000) nx = nx ^ 16'h8005;
    return nx;
  endfunction

  function automatic logic [15:0] model(input int n, input bit sa);
    logic [15:0] s = 16'h0;
    for (int k = 0; k < n; k++) s = misr(s, resp_tab[k] | {1'b0, sa});
    return s;
  endfunction

  task automatic rand_tab();
    for (int k = 0; k < 16; k++) begin
      resp_tab[k] = 2'($urandom_range(0, 3));
      exp_tab[k]  = resp_tab[k];
    end
  endtask

  task automatic drive_start(input logic v);
    if (sel != 0) start_b = v;
    else          start_a = v;
  endtask

  // n vectors, p = SETTLE+1 cycles per vector; checks every edge.
  task automatic run_sweep(input int n, input int p,
                           input logic [15:0] gold, input bit hold);
    logic [15:0] msig [17];
    bit          pass_exp;
    int          errs = 0;
    msig[0] = 16'h0;
    for (int k = 0; k < n; k++)
      msig[k+1] = misr(msig[k], resp_tab[k] | {1'b0, stuck});
`ifdef BIST_EXPECT_EN
    if (sel == 0)
      for (int k = 0; k < n; k++)
        if ((resp_tab[k] | {1'b0, stuck}) != exp_tab[k]) errs++;
`endif
    pass_exp = (msig[n] == gold) && (errs == 0);
    @(negedge clk);
    golden = gold;
    drive_start(1'b1);
    @(posedge clk); #1;
    chk("e0_busy", 32'(o_busy), 1);
    chk("e0_pass_clr", 32'(o_pass), 0);
    chk("e0_pat", 32'(o_pat), 0);
    chk("e0_sig", 32'(o_sig), 0);
    if (!hold) drive_start(1'b0);
    for (int e = 1; e <= n * p + 1; e++) begin
      @(posedge clk); #1;
      if (e == n * p) drive_start(1'b0);
      if (e <= n * p) begin
        chk("pat", 32'(o_pat), (e < n * p) ? e / p : n - 1);
        chk("sig", 32'(o_sig), 32'(msig[e / p]));
        chk("busy", 32'(o_busy), 1);
        chk("done_early", 32'(o_done), 0);
      end else begin
        chk("done", 32'(o_done), 1);
        chk("busy_done", 32'(o_busy), 0);
        chk("pass", 32'(o_pass), 32'(pass_exp));
        chk("final_sig", 32'(o_sig), 32'(msig[n]));
      end
    end
    @(posedge clk); #1;
    chk("done_hold", 32'(o_done), 1);
    chk("pass_hold", 32'(o_pass), 32'(pass_exp));
  endtask

  initial begin
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    stuck = 1'b0; golden = '0; sel = 0;
    rand_tab();
    #12;
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_pass", 32'(pass_a), 0);
    chk("rst_pat", 32'(pat_a), 0);
    chk("rst_sig", 32'(sig_a), 0);
    @(negedge clk); rst_n = 1'b1;

    for (int t = 0; t < 4; t++) begin
      rand_tab();
      run_sweep(8, 2, model(8, 1'b0), 1'b0);
    end
    for (int k = 0; k < 16; k++) begin
      resp_tab[k] = 2'd0; exp_tab[k] = 2'd0;
    end
    run_sweep(8, 2, 16'h0, 1'b0);

    rand_tab();
    resp_tab[0] = 2'd0; exp_tab[0] = 2'd0;
    stuck = 1'b1;
    run_sweep(8, 2, model(8, 1'b0), 1'b0);
    stuck = 1'b0;

    rand_tab();
    @(negedge clk); start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0;
    for (int i = 0; i < 40 && pat_a != 3'd5; i++) begin
      @(posedge clk); #1;
    end
    chk("reach_v5", 32'(pat_a), 5);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy_a), 0);
    chk("mid_rst_done", 32'(done_a), 0);
    chk("mid_rst_pass", 32'(pass_a), 0);
    chk("mid_rst_pat", 32'(pat_a), 0);
    chk("mid_rst_sig", 32'(sig_a), 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_busy", 32'(busy_a), 0);
    chk("idle_done", 32'(done_a), 0);
    chk("idle_pat", 32'(pat_a), 0);

    sel = 1;
    rand_tab();
    run_sweep(4, 4, model(4, 1'b0), 1'b1);
    run_sweep(4, 4, model(4, 1'b0) ^ 16'h1, 1'b0);
    sel = 0;

`ifdef BIST_EXPECT_EN
    rand_tab();
    exp_tab[6] = exp_tab[6] ^ 2'd1;
    run_sweep(8, 2, model(8, 1'b0), 1'b0);
    chk("err_cnt_one", 32'(errc_a), 1);
    chk("first_fail", 32'(ff_a), 6);
    exp_tab[6] = resp_tab[6];
    run_sweep(8, 2, model(8, 1'b0), 1'b0);
    chk("err_cnt_zero", 32'(errc_a), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
